// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end: scan codes, the ASCII
// key bytes the game logic expects, and the frame FSM encoding.
package ps2_pkg;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  localparam logic [7:0] ASCII_W    = 8'h77;
  localparam logic [7:0] ASCII_S    = 8'h73;
  localparam logic [7:0] ASCII_A    = 8'h61;
  localparam logic [7:0] ASCII_D    = 8'h64;
  localparam logic [7:0] ASCII_IDLE = 8'h00;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // Letter keys map only without the E0 prefix, arrows only with it.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code,
                                               input logic       ext);
    logic [7:0] a;
    a = ASCII_IDLE;
    if (!ext) begin
      case (code)
        SC_W:    a = ASCII_W;
        SC_S:    a = ASCII_S;
        SC_A:    a = ASCII_A;
        SC_D:    a = ASCII_D;
        default: a = ASCII_IDLE;
      endcase
    end else begin
      case (code)
        SC_UP:    a = ASCII_W;
        SC_DOWN:  a = ASCII_S;
        SC_LEFT:  a = ASCII_A;
        SC_RIGHT: a = ASCII_D;
        default:  a = ASCII_IDLE;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive path: input synchronisers, ps2_clk glitch filter, 11-bit
// frame FSM with inter-edge timeout. Emits a checked byte or an error pulse.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [1:0]    state;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [TW-1:0] to_cnt;
  logic          err_q;
  logic          frame_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt     <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      fall   <= 1'b0;
      if (clk_s2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= clk_s2;
        filt_cnt <= '0;
        fall     <= filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // shift collects d0..d7, parity, stop (start bit is not stored).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      to_cnt  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall) begin
            if (!dat_s2) begin
              state   <= ST_RECV;
              bit_cnt <= 4'd1;
              to_cnt  <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (fall) begin
            shift   <= {dat_s2, shift[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
            to_cnt  <= '0;
            if (bit_cnt == 4'd10) state <= ST_CHECK;
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            shift <= '0;
            state <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_CHECK: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign frame_ok = shift[9] & (^shift[8:0]);
  assign rx_byte  = shift[7:0];
  assign rx_valid = (state == ST_CHECK) && frame_ok;
  assign rx_err   = err_q || ((state == ST_CHECK) && !frame_ok);

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to game-control decoder: handles E0/F0 prefixes, suppresses
// typematic repeats and strobes the ASCII key byte (00 on release).
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       display,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       brk, ext;
  logic [7:0] held, data_q;
  logic [7:0] mapped, next_data;
  logic       is_prefix, strobe;

  ps2_rx_frame #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  always_comb begin
    mapped    = scan_to_ascii(rx_byte, ext);
    is_prefix = (rx_byte == SC_EXT) || (rx_byte == SC_BRK);
    strobe    = 1'b0;
    next_data = data_q;
    if (rx_valid && !is_prefix) begin
      if (!brk) begin
        if (mapped != ASCII_IDLE && mapped != held) begin
          strobe    = 1'b1;
          next_data = mapped;
        end
      end else if (mapped == held && held != ASCII_IDLE) begin
        strobe    = 1'b1;
        next_data = ASCII_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brk    <= 1'b0;
      ext    <= 1'b0;
      held   <= ASCII_IDLE;
      data_q <= ASCII_IDLE;
    end else begin
      if (rx_valid) begin
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end
      if (strobe) begin
        held   <= next_data;
        data_q <= next_data;
      end
    end
  end

  // The strobe is decided in the frame's check cycle, so data is bypassed
  // to show the new byte in the same cycle display is high.
  assign display   = strobe;
  assign data      = strobe ? next_data : data_q;
  assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: frames are bit-banged on the PS/2 pins,
// expected strobes/errors are queued and checked as the DUT emits them.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       display;
  logic       frame_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         is_strobe;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];

  ps2_key_decoder #(
    .FILTER_LEN(8),
    .TIMEOUT   (20000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data     (data),
    .display  (display),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && (display || frame_err)) begin
      tests++;
      assert (!(display && frame_err)) else begin
        fails++;
        $error("FAIL both_high display=%0b frame_err=%0b required not both", display, frame_err);
      end
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_event display=%0b frame_err=%0b data=%02h required no event",
               display, frame_err, data);
      end
      if (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        tests++;
        assert (display === e.is_strobe) else begin
          fails++;
          $error("FAIL event_kind display=%0b required %0b", display, e.is_strobe);
        end
        if (e.is_strobe) begin
          tests++;
          assert (data === e.data) else begin
            fails++;
            $error("FAIL strobe_data data=%02h required %02h", data, e.data);
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // nbits < 11 sends a truncated frame; bad_par inverts the parity bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cycles(20);
      ps2_clk = 1'b0;
      cycles(40);
      ps2_clk = 1'b1;
      cycles(20);
    end
    ps2_data = 1'b1;
  endtask

  task automatic push(input bit s, input logic [7:0] d);
    ev_t e;
    e.is_strobe = s;
    e.data      = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    cycles(30);
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL %s pending_events=%0d required 0", tag, exp_q.size());
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%02h required %02h", tag, got, want);
    end
  endtask

  initial begin
    cycles(3);
    check8("reset_data", data, 8'h00);
    check8("reset_display", {7'd0, display}, 8'h00);
    check8("reset_frame_err", {7'd0, frame_err}, 8'h00);
    rst = 1'b1;
    cycles(20);

    push(1, 8'h77);
    send_frame(8'h1D, 0, 11);
    drain("make_w");

    send_frame(8'h1D, 0, 11);
    send_frame(8'h1D, 0, 11);
    drain("typematic");
    push(1, 8'h00);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h1D, 0, 11);
    drain("break_w");

    push(1, 8'h61);
    send_frame(8'hE0, 0, 11);
    send_frame(8'h6B, 0, 11);
    drain("ext_left_make");
    push(1, 8'h00);
    send_frame(8'hE0, 0, 11);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h6B, 0, 11);
    drain("ext_left_break");

    push(0, 8'h00);
    send_frame(8'h23, 1, 11);
    drain("bad_parity");
    check8("data_kept_after_err", data, 8'h00);

    send_frame(8'h1B, 0, 5);
    push(0, 8'h00);
    cycles(20100);
    drain("timeout");
    push(1, 8'h73);
    send_frame(8'h1B, 0, 11);
    drain("make_s_after_timeout");

    ps2_clk = 1'b0;
    cycles(3);
    ps2_clk = 1'b1;
    cycles(50);
    drain("glitch");
    check8("data_after_glitch", data, 8'h73);

    send_frame(8'h1C, 0, 4);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check8("async_reset_data", data, 8'h00);
    check8("async_reset_display", {7'd0, display}, 8'h00);
    check8("async_reset_frame_err", {7'd0, frame_err}, 8'h00);
    cycles(5);
    rst = 1'b1;
    cycles(20);
    push(1, 8'h61);
    send_frame(8'h1C, 0, 11);
    drain("make_a_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
